// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_queue_pkg;

  // PC of the first fetch after reset unless the instance overrides it.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // addi x0, x0, 0. This value is driven on inst whenever the queue head is empty.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // One buffered fetch: the request PC, the returned word and its access-fault flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Instruction fetches are always word aligned, so the low two address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Synchronous FIFO with flush. The head word is read straight out of the
// storage flops, so it is stable for as long as it is not popped.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty queue is ignored. Flush overrides both push and pop.
  assign do_pop     = pop && (count != '0) && !flush;
  assign do_push    = push && !flush;
  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

  // Storage write. A valid entry is always written before it is read.
  // NOTE: the storage array is not reset. Only the pointers and count say what is valid, so clearing the data would cost flops and buy nothing.
  // NOTE: sequential state always uses non-blocking (<=) assignments, so every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking. Reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // The producer must never push into a full queue unless the head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_push && (count == DEPTH_C) && !do_pop));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end. It owns the fetch PC, issues in-order word
// requests to instruction memory, buffers the returned words with their PCs
// and hands them to decode. A redirect flushes the queue and discards any
// responses that are still in flight.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_error,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_error
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // pc is the address of the next request. resp_pc is the PC that belongs to the next response that will be kept.
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] occupancy;
  logic [CW:0]   credit_used;
  logic          req_accept;
  logic          pop;
  logic          push;
  logic          resp_drop;
  logic          head_valid;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head_entry;

  // Decode handshake. The head is visible only outside reset.
  assign inst_valid = !rst && head_valid;
  assign pop        = inst_valid && inst_ready;
  assign inst       = inst_valid ? head_entry.inst : NOP_INST;
  assign inst_pc    = head_entry.pc;
  assign inst_error = inst_valid && head_entry.err;

  // Credit check. Requests in flight plus words buffered after this cycle's pop
  // must stay below DEPTH, so every response is guaranteed a queue slot.
  assign credit_used    = {1'b0, outstanding} + {1'b0, occupancy} - {{CW{1'b0}}, pop};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < {1'b0, DEPTH_C});
  assign imem_req_addr  = word_align(pc);
  assign req_accept     = imem_req_valid && imem_req_ready;

  // A response is dropped while stale requests from before a redirect are still returning.
  // A response that arrives together with a redirect is also discarded.
  assign resp_drop = imem_resp_valid && (drop != '0);
  assign push      = imem_resp_valid && !resp_drop && !redirect_valid;
  assign wr_entry  = '{pc: resp_pc, inst: imem_resp_data, err: imem_resp_error};

  // Fetch PC. A redirect overrides everything; otherwise pc steps one word per accepted request and wraps at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= word_align(RESET_PC);
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
    end else if (req_accept) begin
      pc <= pc + 32'd4;
    end
  end

  // Response PC. Responses return in order, so the PC of each kept word is
  // one word after the previous kept word. Dropped responses do not advance it.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_pc <= word_align(RESET_PC);
    end else if (redirect_valid) begin
      resp_pc <= word_align(redirect_pc);
    end else if (push) begin
      resp_pc <= resp_pc + 32'd4;
    end
  end

  // In-flight and to-be-dropped counters. On a redirect, every request still in flight becomes stale.
  // No request is accepted in a redirect cycle, so that branch only retires a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      outstanding <= outstanding - CW'(imem_resp_valid);
      drop        <= outstanding - CW'(imem_resp_valid);
    end else begin
      outstanding <= outstanding + CW'(req_accept) - CW'(imem_resp_valid);
      if (resp_drop) begin
        drop <= drop - 1'b1;
      end
    end
  end

  fifo_sync #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .wdata      (wr_entry),
    .pop        (pop),
    .head       (head_entry),
    .head_valid (head_valid),
    .count      (occupancy)
  );

  a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
    outstanding <= DEPTH_C);
  a_drop_bound: assert property (@(posedge clk) disable iff (rst)
    drop <= outstanding);
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, outstanding} + {1'b0, occupancy}) <= {1'b0, DEPTH_C});
  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue. Memory is modelled as an in-order
// response queue with a programmable latency. The expected decode stream is
// the architectural PC sequence: it starts at the reset or redirect PC and
// advances one word per consumed instruction.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_error;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_error;

  always #5 clk = ~clk;

  ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_error (imem_resp_error),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_error      (inst_error)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] req_log[$];
  int          cyc, last_due, lat_min, lat_max;
  int          n_checks, n_pass, n_pops;
  logic        rst_drv;
  logic [31:0] exp_pc, exp_req;
  logic        prev_hold, prev_err;
  logic [31:0] prev_pc, prev_inst;
  logic        obs_req_valid, obs_inst_valid, obs_inst_err;
  logic [31:0] obs_req_addr, obs_inst_pc;

  // Memory contents and fault map are fixed functions of the address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic fault_of(input logic [31:0] a);
    return a[5:2] == 4'h2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One clock cycle. Inputs are driven on the falling edge, outputs are sampled 1ns later,
  // and then the bench waits for the rising edge.
  task automatic step(input logic req_rdy, input logic dec_rdy, input logic redir,
                      input logic [31:0] rpc);
    int t_due;
    @(negedge clk);
    rst = rst_drv;
    if (!rst_drv && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word_of(mem_q[0].addr);
      imem_resp_error = fault_of(mem_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
      imem_resp_error = 1'b0;
    end
    imem_req_ready = req_rdy;
    inst_ready     = dec_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    obs_req_valid  = imem_req_valid;
    obs_req_addr   = imem_req_addr;
    obs_inst_valid = inst_valid;
    obs_inst_pc    = inst_pc;
    obs_inst_err   = inst_error;
    if (rst) begin
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      mem_q.delete();
      last_due  = 0;
      exp_pc    = 32'h0;
      exp_req   = 32'h0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_pc", inst_pc, prev_pc);
        check("hold_inst", inst, prev_inst);
        check("hold_err", 32'(inst_error), 32'(prev_err));
      end
      if (redir) check("redirect_no_req", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req);
      if (inst_valid && inst_ready && !redir) begin
        check("pop_pc", inst_pc, exp_pc);
        check("pop_inst", inst, word_of(exp_pc));
        check("pop_err", 32'(inst_error), 32'(fault_of(exp_pc)));
        pop_log.push_back(inst_pc);
        n_pops++;
        exp_pc += 32'd4;
      end
      if (imem_resp_valid) void'(mem_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        t_due = cyc + int'($urandom_range(lat_max, lat_min));
        if (t_due < last_due) t_due = last_due;
        mem_q.push_back('{addr: imem_req_addr, due: t_due});
        last_due = t_due;
        req_log.push_back(imem_req_addr);
        exp_req += 32'd4;
      end
      if (redir) begin
        exp_pc  = {rpc[31:2], 2'b00};
        exp_req = {rpc[31:2], 2'b00};
      end
      prev_hold = inst_valid && !inst_ready && !redir;
      prev_pc   = inst_pc;
      prev_inst = inst;
      prev_err  = inst_error;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    rst_drv = 1'b0;
    pop_log.delete();
    req_log.delete();
  endtask

  initial begin
    int pops_start;
    n_checks = 0; n_pass = 0; n_pops = 0; cyc = 0; last_due = 0;
    lat_min = 1; lat_max = 1;
    rst_drv = 1'b1; rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    imem_resp_error = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    prev_hold = 1'b0; exp_pc = 32'h0; exp_req = 32'h0;

    // Streaming with a 1-cycle memory: first valid in cycle 3, then one instruction per cycle. Only pc 0x8 faults.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (k == 1) check("first_req_valid", 32'(obs_req_valid), 32'd1);
      if (k <= 2) check("first_valid_early", 32'(obs_inst_valid), 32'd0);
      else begin
        check("stream_valid", 32'(obs_inst_valid), 32'd1);
        check("stream_pc", obs_inst_pc, 32'(4 * (k - 3)));
        check("stream_err", 32'(obs_inst_err), 32'((k - 3) == 2));
      end
    end

    // Decode stall: two entries buffered, requests blocked, and a clean restart when decode resumes.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (k >= 3) check("stall_req_blocked", 32'(obs_req_valid), 32'd0);
    end
    check("stall_head_valid", 32'(obs_inst_valid), 32'd1);
    check("stall_head_pc", obs_inst_pc, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("release_valid", 32'(obs_inst_valid), 32'd1);
      check("release_pc", obs_inst_pc, 32'(4 * k));
    end

    // Redirect with two responses outstanding on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    for (int i = 0; i < 20 && pop_log.size() < 2; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_pop_count", 32'(pop_log.size() >= 2), 32'd1);
    if (pop_log.size() >= 2) begin
      check("redir_first_pc", pop_log[0], 32'h100);
      check("redir_second_pc", pop_log[1], 32'h104);
    end

    // Redirect coinciding with a response and a pop. The target is misaligned and must be word-aligned.
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h202);
    check("flush_pop_pending", 32'(obs_inst_valid), 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("flush_empty", 32'(obs_inst_valid), 32'd0);
    check("flush_req_valid", 32'(obs_req_valid), 32'd1);
    check("flush_req_addr", obs_req_addr, 32'h200);

    // PC wrap at the top of the address space.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 10 && pop_log.size() < 2; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_req_count", 32'(req_log.size() >= 2), 32'd1);
    if (req_log.size() >= 2) begin
      check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
      check("wrap_req1", req_log[1], 32'h0000_0000);
    end
    check("wrap_pop_count", 32'(pop_log.size() >= 2), 32'd1);
    if (pop_log.size() >= 2) check("wrap_pop1", pop_log[1], 32'h0000_0000);

    // Random traffic: variable latency, random stalls on both sides, random redirects and occasional resets.
    lat_min = 1; lat_max = 4;
    do_reset();
    pops_start = n_pops;
    for (int i = 0; i < 4000; i++) begin
      logic        redir;
      logic [31:0] rpc;
      redir = ($urandom_range(99, 0) < 3);
      rpc   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                          : 32'($urandom);
      step($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7, redir, rpc);
      if (i % 1500 == 1499) do_reset();
    end
    check("random_progress", 32'((n_pops - pops_start) > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Front end of the 5-stage core; replaces the free-running fetch stage.
- Owns the PC and issues in-order word requests to the instruction memory over a valid/ready request channel plus a response channel.
- Buffers returned words with their PC in a small queue and presents them to decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset
DEPTH, 2, queue entries; also caps outstanding-plus-buffered requests (power of 2, >= 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_resp_valid  in  1  response valid (in order, >=1 cycle after accept)
imem_resp_data  in  32  instruction word
imem_resp_error  in  1  access fault for this response
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC
inst_valid  out  1  queue head valid
inst_ready  in  1  decode consumes head
inst  out  32  head instruction
inst_pc  out  32  head PC
inst_error  out  1  head carried an access fault

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - pc=RESET_PC; queue empty; outstanding=0; drop=0.
  - inst_valid=0, imem_req_valid=0 while rst is high.
  - First request is issued in the cycle after rst deasserts.
- Request accept: imem_req_valid && imem_req_ready in the same cycle. Valid may drop without acceptance; the memory side must tolerate this. imem_req_addr = {pc[31:2],2'b00}.
- Credit rule:
  - imem_req_valid = !rst && !redirect_valid && (outstanding + occupancy - pop) < DEPTH, where pop = inst_valid && inst_ready.
  - On accept: pc += 4 (wraps at 2^32) and outstanding += 1.
- Response: on imem_resp_valid, outstanding -= 1.
  - If drop > 0, the response is discarded and drop -= 1.
  - Otherwise {pc_of_request, data, error} is written to the queue.
  - The credit rule guarantees the queue never overflows.
- Request PCs are tracked in a DEPTH-deep in-flight PC FIFO, or derived from a head-PC counter; either implementation is allowed.
- Output:
  - Head is registered; inst_valid rises the cycle after the response edge.
  - With a 1-cycle memory, sustained throughput is 1 inst/cycle when DEPTH=2.
- Head stability: while inst_valid && !inst_ready, inst, inst_pc and inst_error hold stable.
- Redirect (highest priority):
  - At the edge: queue cleared; pc = {redirect_pc[31:2],2'b00}; drop = outstanding minus any response arriving this cycle; that response is discarded.
  - A pop in the same cycle is ignored (flush wins).
  - No request is issued in the redirect cycle.
  - The first request for redirect_pc is issued the next cycle.
  - Back-to-back redirects: the last one wins; drop accumulates correctly.
- Errors: an access fault does not stop fetch. inst_error accompanies that entry only; the pipeline decides what to do.
- Counters: outstanding and drop are clog2(DEPTH)+1 bits wide and never exceed DEPTH (assert).
- Memory stall (imem_req_ready=0 indefinitely): pc holds; queue drains normally.

Decomposition:
- common package:
  - typedef FetchEntry {logic [31:0] pc; logic [31:0] inst; logic err;}
  - constant RESET_PC_DEFAULT
  - constant NOP_INST = 32'h0000_0013
- Sub-module fifo_sync (parameterised width/depth, flush input, registered head) holds FetchEntry. ifetch_queue keeps the PC, counters and handshake logic.

Test Plan:
- Reset, then 1-cycle memory, inst_ready=1 -> inst_pc 0x0,0x4,0x8,... on consecutive cycles; first inst_valid at cycle 3 after rst falls.
- inst_ready=0 for 5 cycles -> exactly 2 entries buffered, imem_req_valid=0, head holds pc 0x0. Releasing ready -> 0x0,0x4,0x8 with no gap or duplicate.
- Redirect to 0x100 with 2 responses outstanding (3-cycle memory) -> both stale responses dropped; next inst_pc=0x100, then 0x104.
- Redirect in the same cycle as a response and a pop -> the response is discarded and the queue is empty next cycle. The next imem_req_addr is redirect_pc.
- imem_resp_error=1 on pc 0x8 -> inst_error=1 only with inst_pc 0x8; 0xC follows with error 0.
- pc=0xFFFF_FFFC sequence -> the next request address wraps to 0x0000_0000.
